// File: rtl/pu_feeder.sv
// pu_feeder: serial frame loader, settle timer and result port for the 8-input PU.
// Optional build macro PU_FEEDER_RELU_EN applies ReLU to the captured result.
module pu_feeder #(
  parameter int size   = 16,
  parameter int SETTLE = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [size-1:0]   in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [8*size-1:0] pu_x,
  output logic [8*size-1:0] pu_w,
  output logic [size-1:0]   pu_bias,
  input  logic [size-1:0]   pu_out,
  output logic [size-1:0]   res_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_SETTLE,
    ST_RESULT
  } state_t;

  state_t          state;
  logic [4:0]      cnt;
  logic [3:0]      scnt;
  logic [size-1:0] cap;

  // value captured at the end of the settle window
  always_comb begin
`ifdef PU_FEEDER_RELU_EN
    cap = pu_out[size-1] ? '0 : pu_out;
`else
    cap = pu_out;
`endif
  end

  // frame loader, settle timer and result handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_LOAD;
      cnt       <= '0;
      scnt      <= '0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      pu_x      <= '0;
      pu_w      <= '0;
      pu_bias   <= '0;
    end else begin
      unique case (state)
        ST_LOAD: begin
          if (in_valid) begin
            // beats 0..7 x, 8..15 w, 16 bias
            unique case (1'b1)
              cnt[4]:  pu_bias <= in_data;
              cnt[3]:  pu_w[cnt[2:0]*size +: size] <= in_data;
              default: pu_x[cnt[2:0]*size +: size] <= in_data;
            endcase
            if (cnt == 5'd16) begin
              cnt      <= '0;
              scnt     <= '0;
              state    <= ST_SETTLE;
              in_ready <= 1'b0;
              busy     <= 1'b1;
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
        end
        ST_SETTLE: begin
          scnt <= scnt + 4'd1;
          if (scnt == 4'(SETTLE - 1)) begin
            res_data  <= cap;
            res_valid <= 1'b1;
            state     <= ST_RESULT;
          end
        end
        ST_RESULT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= ST_LOAD;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state    <= ST_LOAD;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pu_feeder.sv
// tb_pu_feeder: directed frame vectors against a behavioural PU model.
// Checks results, latency, stalls, result back-pressure and reset.
module tb_pu_feeder;

  localparam int SZ = 16;
  localparam int ST = 2;
  localparam int FR = 17 + ST + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [SZ-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [8*SZ-1:0] pu_x, pu_w;
  logic [SZ-1:0] pu_bias, pu_out, res_data;
  logic          res_valid, busy;
  logic          res_ready = 1'b1;
  int            cyc = 0;
  int            nchk = 0;
  int            nerr = 0;

  pu_feeder #(.size(SZ), .SETTLE(ST)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .pu_x(pu_x), .pu_w(pu_w), .pu_bias(pu_bias), .pu_out(pu_out),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // behavioural PU: low bits of bias + sum(x*w)
  always_comb begin
    logic [SZ-1:0] acc;
    acc = pu_bias;
    for (int i = 0; i < 8; i++)
      acc = acc + SZ'(pu_x[i*SZ +: SZ] * pu_w[i*SZ +: SZ]);
    pu_out = acc;
  end

  typedef struct {
    logic [7:0][SZ-1:0] x;
    logic [7:0][SZ-1:0] w;
    logic [SZ-1:0]      b;
    int                 stall_at;
    int                 stall_len;
    int                 hold;
    logic [SZ-1:0]      exp;
  } vec_t;

  vec_t tv[5];

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic send_beat(input logic [SZ-1:0] d);
    int t;
    t = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) chk("ready_timeout", 128'(in_ready), 128'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_frame(input vec_t v, output int first_cyc,
                           output int hs_cyc);
    int k;
    logic [SZ-1:0] d;
    res_ready = (v.hold == 0);
    first_cyc = 0;
    for (int b = 0; b < 17; b++) begin
      d = (b < 8) ? v.x[b] : (b < 16) ? v.w[b-8] : v.b;
      send_beat(d);
      if (b == 0) first_cyc = cyc;
      if (b == v.stall_at)
        for (int s = 0; s < v.stall_len; s++) begin
          @(posedge clk); #1;
          chk("stall_rdy", 128'(in_ready), 128'(1));
          chk("stall_busy", 128'(busy), 128'(0));
        end
    end
    chk("busy_set", 128'(busy), 128'(1));
    chk("rdy_drop", 128'(in_ready), 128'(0));
    chk("pu_x", 128'(pu_x), 128'(v.x));
    chk("pu_w", 128'(pu_w), 128'(v.w));
    chk("pu_bias", 128'(pu_bias), 128'(v.b));
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (!res_valid && k < 40);
    chk("latency", 128'(k), 128'(ST));
    chk("res_data", 128'(res_data), 128'(v.exp));
    for (int h = 0; h < v.hold; h++) begin
      in_valid = 1'b1;
      in_data  = 16'hBEEF;
      @(posedge clk); #1;
      chk("hold_valid", 128'(res_valid), 128'(1));
      chk("hold_data", 128'(res_data), 128'(v.exp));
      chk("hold_rdy", 128'(in_ready), 128'(0));
    end
    in_valid  = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    hs_cyc = cyc;
    chk("hs_valid", 128'(res_valid), 128'(0));
    chk("hs_rdy", 128'(in_ready), 128'(1));
    chk("hs_busy", 128'(busy), 128'(0));
  endtask

  initial begin
    int f0, h0, f1, h1;
    logic [SZ-1:0] neg;
`ifdef PU_FEEDER_RELU_EN
    neg = 16'h0000;
`else
    neg = 16'hFFDC;
`endif
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 8; j++) begin
        tv[i].x[j] = SZ'(j + 1);
        tv[i].w[j] = 16'h0001;
      end
      tv[i].b         = 16'h0004;
      tv[i].stall_at  = 99;
      tv[i].stall_len = 0;
      tv[i].hold      = 0;
      tv[i].exp       = 16'h0028;
    end
    tv[1].stall_at  = 9;
    tv[1].stall_len = 5;
    for (int j = 0; j < 8; j++) tv[2].w[j] = 16'hFFFF;
    tv[2].b   = 16'h0000;
    tv[2].exp = neg;
    tv[3].hold = 10;
    for (int j = 0; j < 8; j++) begin
      tv[4].x[j] = 16'h0002;
      tv[4].w[j] = 16'h0003;
    end
    tv[4].b   = 16'h0010;
    tv[4].exp = 16'h0040;

    #12;
    chk("rst_rdy", 128'(in_ready), 128'(1));
    chk("rst_valid", 128'(res_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_data", 128'(res_data), 128'(0));
    chk("rst_pu_x", 128'(pu_x), 128'(0));
    chk("rst_pu_w", 128'(pu_w), 128'(0));
    chk("rst_bias", 128'(pu_bias), 128'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) run_frame(tv[i], f0, h0);

    for (int b = 0; b < 13; b++) send_beat(16'h00AA);
    rst = 1'b1;
    #1;
    chk("mid_rst_rdy", 128'(in_ready), 128'(1));
    chk("mid_rst_busy", 128'(busy), 128'(0));
    chk("mid_rst_x", 128'(pu_x), 128'(0));
    chk("mid_rst_w", 128'(pu_w), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    run_frame(tv[0], f0, h0);

    run_frame(tv[0], f0, h0);
    run_frame(tv[4], f1, h1);
    chk("b2b_start", 128'(f1 - f0), 128'(FR));
    chk("b2b_total", 128'(h1 - f0 + 1), 128'(2 * FR));

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
